// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the FND scan path: conversion state encoding, BCD
// nibble width, display limit, default digit count, the all-off anode pattern
// and the double-dabble add-3 helper.
// -----------------------------------------------------------------------------
package fnd_pkg;

   localparam int          BCD_W          = 4;
   localparam int          MAX_DISPLAY    = 9999;
   localparam int          NUM_DIGITS_DEF = 4;
   localparam logic [3:0]  DIG_SEL_IDLE   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_UPDATE = 2'd2
   } conv_state_e;

   // Double-dabble correction: every nibble >= 5 gets +3 so that the
   // following left shift carries correctly into the next decimal digit.
   function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
            res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
         end else begin
            res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// -----------------------------------------------------------------------------
// bin2bcd_serial
// Sequential binary-to-BCD converter (one shift/add-3 step per clock).
// Values above MAX_DISPLAY are clamped to MAX_DISPLAY and flagged.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_value        : binary input, captured when i_start is seen in IDLE
//   i_start        : load strobe (ignored while busy)
//   o_busy         : high from the load edge until the result is published
//   o_done         : high for the single UPDATE cycle (o_bcd valid)
//   o_overflow     : clamp flag of the most recently published result
//   o_bcd          : four packed BCD digits, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_serial
   import fnd_pkg::*;
#(
   parameter int VALUE_W = 14
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [VALUE_W-1:0] i_value,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow,
   output logic [15:0]        o_bcd
);

   localparam int                STEP_W    = $clog2(VALUE_W);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(VALUE_W - 1);

   conv_state_e        state_q, state_d;
   logic [VALUE_W-1:0] bin_q, bin_d;
   logic [15:0]        bcd_q, bcd_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        adj_s;

   // Next-state logic for the load / convert / publish sequence.
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      step_d     = step_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      adj_s      = dd_adjust(bcd_q);
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               if (32'(i_value) > MAX_DISPLAY) begin
                  bin_d      = VALUE_W'(MAX_DISPLAY);
                  ovf_pend_d = 1'b1;
               end else begin
                  bin_d      = i_value;
                  ovf_pend_d = 1'b0;
               end
               bcd_d   = 16'd0;
               step_d  = {STEP_W{1'b0}};
               state_d = ST_CONV;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONV: begin
            // Shift {adjusted bcd, bin} left by one as a single vector.
            bcd_d = {adj_s[14:0], bin_q[VALUE_W-1]};
            bin_d = {bin_q[VALUE_W-2:0], 1'b0};
            if (step_q == STEP_LAST) begin
               state_d = ST_UPDATE;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_UPDATE: begin
            ovf_d   = ovf_pend_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_UPDATE);
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         bin_q      <= {VALUE_W{1'b0}};
         bcd_q      <= 16'd0;
         step_q     <= {STEP_W{1'b0}};
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         step_q     <= step_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_overflow = ovf_q;
   assign o_bcd      = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
// Converts a binary value to BCD and time-multiplexes four 7-segment digits.
// Optional feature macro: FND_LEADING_ZERO_BLANK_EN (leading-zero blanking).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_value        : binary value to display
//   i_load         : one-cycle load strobe, accepted when not busy
//   o_busy         : conversion in progress
//   o_overflow     : last loaded value exceeded 9999 (shown as 9999)
//   o_bcd          : nibble of the selected digit (to decoder i_value)
//   o_blank        : blank the selected digit (to decoder i_en)
//   o_digit_sel    : active-low one-hot anode select
// -----------------------------------------------------------------------------
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [VALUE_W-1:0]    i_value,
   input  logic                  i_load,
   output logic                  o_busy,
   output logic                  o_overflow,
   output logic [BCD_W-1:0]      o_bcd,
   output logic                  o_blank,
   output logic [NUM_DIGITS-1:0] o_digit_sel
);

   localparam int               CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic                  cnv_done_s;
   logic [15:0]           cnv_bcd_s;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            idx_q, idx_d;
   logic [15:0]           disp_q, disp_d;
   logic                  valid_q, valid_d;
   logic [BCD_W-1:0]      bcd_q, bcd_d;
   logic                  blank_q, blank_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  lz_s;

   bin2bcd_serial #(
      .VALUE_W (VALUE_W)
   ) u_bin2bcd (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_value    (i_value),
      .i_start    (i_load),
      .o_busy     (o_busy),
      .o_done     (cnv_done_s),
      .o_overflow (o_overflow),
      .o_bcd      (cnv_bcd_s)
   );

   // Scan timing, display register and the registered output mux.
   // The outputs are computed from the next-cycle index and display so a
   // digit change and a display update appear on the very same edge.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d = {CNT_W{1'b0}};
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         idx_d = idx_q;
      end

      if (cnv_done_s) begin
         disp_d  = cnv_bcd_s;
         valid_d = 1'b1;
      end else begin
         disp_d  = disp_q;
         valid_d = valid_q;
      end

      // lz_s: selected digit and every higher digit are zero (digit 0 exempt).
      case (idx_d)
         2'd0: begin bcd_d = disp_d[3:0];   lz_s = 1'b0;                   end
         2'd1: begin bcd_d = disp_d[7:4];   lz_s = (disp_d[15:4]  == 12'd0); end
         2'd2: begin bcd_d = disp_d[11:8];  lz_s = (disp_d[15:8]  == 8'd0);  end
         2'd3: begin bcd_d = disp_d[15:12]; lz_s = (disp_d[15:12] == 4'd0);  end
         default: begin bcd_d = 4'd0;       lz_s = 1'b0;                   end
      endcase

      if (!valid_d) begin
         blank_d = 1'b1;
      end else begin
`ifdef FND_LEADING_ZERO_BLANK_EN
         blank_d = lz_s;
`else
         blank_d = 1'b0;
`endif
      end

      sel_d = DIG_SEL_IDLE ^ (4'b0001 << idx_d);
   end

   // Scan, display and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= {CNT_W{1'b0}};
         idx_q   <= 2'd0;
         disp_q  <= 16'd0;
         valid_q <= 1'b0;
         bcd_q   <= 4'd0;
         blank_q <= 1'b1;
         sel_q   <= 4'b1110;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         valid_q <= valid_d;
         bcd_q   <= bcd_d;
         blank_q <= blank_d;
         sel_q   <= sel_d;
      end
   end

   assign o_bcd       = bcd_q;
   assign o_blank     = blank_q;
   assign o_digit_sel = sel_q;

endmodule
